// File: rtl/plot_stream_decoder.sv
// plot_stream_decoder
//
// Receiving end of the lane pixel-plot stream (x, y, colour, plot) that the
// displayer drives toward the VGA adapter. It rebuilds the three-lane
// note-strip vector (do/re/mi, ROWS rows each) from the plotted pixels.
// It also checks pixel order and per-row colour consistency, and then
// publishes each validated frame on data.
//
// Ports
//   clock        system clock, rising-edge active
//   resetn       asynchronous active-low reset
//   wren         writer side updating: aborts the frame and holds IDLE
//   plot         pixel strobe; x/y/colour valid when high
//   x, y         pixel column / row
//   colour       pixel colour (000 dark, LIT_COLOUR lit)
//   data         last published frame, bit lane*ROWS+row (do=0, re=1, mi=2)
//   frame_valid  one-cycle pulse when data updates
//   seq_error    sticky: out-of-order / out-of-range pixel (or watchdog)
//   lane_error   sticky per lane: inconsistent row colour or illegal colour
//   busy         in CAPTURE with at least one pixel of the frame accepted
//
// Optional feature: define PLOT_STREAM_TIMEOUT_EN to add an idle watchdog.
// While a frame is in progress and no pixel arrives for TIMEOUT_CYCLES
// cycles, seq_error is set and the frame is abandoned (ERROR). Without the
// macro, CAPTURE waits indefinitely.

module plot_stream_decoder #(
    parameter logic [2:0]  LIT_COLOUR     = 3'b100,
    parameter int unsigned X_DO           = 50,
    parameter int unsigned X_RE           = 76,
    parameter int unsigned X_MI           = 102,
    parameter int unsigned ROWS           = 120,
    parameter int unsigned LANE_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wren,
    input  logic              plot,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    output logic [3*ROWS-1:0] data,
    output logic              frame_valid,
    output logic              seq_error,
    output logic [2:0]        lane_error,
    output logic              busy
);

    // The idle watchdog counter is 13 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must fit the 13-bit idle counter");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;

    // Expected-position tracker: col fastest, then row, then lane.
    logic [1:0] lane;
    logic [6:0] row;
    logic [2:0] col;

    // Colour seen at col 0 of the current row; later columns must match it.
    logic [2:0] row_colour;

    logic [3*ROWS-1:0] shadow;

    logic [7:0] lane_base;
    logic [7:0] exp_x;
    logic       hit;
    logic       last_px;
    logic       colour_ok;
    logic [8:0] bit_idx;
    logic       timeout_hit;

    always_comb begin
        unique case (lane)
            2'd0:    lane_base = 8'(X_DO);
            2'd1:    lane_base = 8'(X_RE);
            default: lane_base = 8'(X_MI);
        endcase
        exp_x     = lane_base + 8'(col);
        hit       = (x == exp_x) && (y == row);
        last_px   = (lane == 2'd2) && (row == 7'(ROWS - 1)) &&
                    (col == 3'(LANE_W - 1));
        colour_ok = (colour == 3'b000) || (colour == LIT_COLOUR);
        bit_idx   = 9'(lane) * 9'(ROWS) + 9'(row);
    end

`ifdef PLOT_STREAM_TIMEOUT_EN
    logic [12:0] idle_cnt;

    // Counts consecutive plot-free cycles inside an in-progress frame. Any
    // plot in CAPTURE either advances the tracker or leaves CAPTURE, so
    // plot alone is enough to clear it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else if (wren || state != S_CAPTURE || plot || !busy || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 13'd1;
        end
    end

    assign timeout_hit = (state == S_CAPTURE) && busy && !plot &&
                         (idle_cnt == 13'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            lane        <= '0;
            row         <= '0;
            col         <= '0;
            row_colour  <= '0;
            shadow      <= '0;
            data        <= '0;
            frame_valid <= 1'b0;
            seq_error   <= 1'b0;
            lane_error  <= '0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (wren) begin
                // Writer side owns the display: drop the frame, keep data.
                state      <= S_IDLE;
                lane       <= '0;
                row        <= '0;
                col        <= '0;
                seq_error  <= 1'b0;
                lane_error <= '0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        lane  <= '0;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b0;
                        state <= S_CAPTURE;
                    end

                    S_CAPTURE: begin
                        if (plot) begin
                            if (hit) begin
                                if (col == 3'd0) begin
                                    shadow[bit_idx] <= (colour == LIT_COLOUR);
                                    row_colour      <= colour;
                                end else if (colour != row_colour) begin
                                    lane_error[lane] <= 1'b1;
                                end
                                if (!colour_ok) begin
                                    lane_error[lane] <= 1'b1;
                                end

                                if (col == 3'(LANE_W - 1)) begin
                                    col <= '0;
                                    if (row == 7'(ROWS - 1)) begin
                                        row  <= '0;
                                        lane <= lane + 2'd1;
                                    end else begin
                                        row <= row + 7'd1;
                                    end
                                end else begin
                                    col <= col + 3'd1;
                                end

                                if (last_px) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                end else begin
                                    busy <= 1'b1;
                                end
                            end else begin
                                seq_error <= 1'b1;
                                busy      <= 1'b0;
                                state     <= S_ERROR;
                            end
                        end else if (timeout_hit) begin
                            seq_error <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_ERROR;
                        end
                    end

                    S_DONE: begin
                        // Publish regardless of lane_error; flags qualify it.
                        data        <= shadow;
                        frame_valid <= 1'b1;
                        lane        <= '0;
                        row         <= '0;
                        col         <= '0;
                        busy        <= 1'b0;
                        state       <= S_CAPTURE;
                    end

                    S_ERROR: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
